// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request channel, decode handshake,
// redirect input and the handshake counter.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 19
);
  localparam int unsigned COUNT_WIDTH = 16;

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  pc_out;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_target;
  logic [COUNT_WIDTH-1:0] fetch_count;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out, fetch_count,
    input  imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_target
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out, fetch_count,
    output imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, holds the returned
// word with its PC until decode accepts it, and squashes work made stale by a
// branch/jump redirect. All bus outputs are registered.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 19,
  parameter int unsigned RESET_PC    = 0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned COUNT_WIDTH = 16;
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic [1:0]             state,    state_nxt;
  logic [ADDR_WIDTH-1:0]  pc,       pc_nxt;
  logic                   req_q,    req_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q,   addr_nxt;
  logic                   valid_q,  valid_nxt;
  logic [INSTR_WIDTH-1:0] instr_q,  instr_nxt;
  logic [ADDR_WIDTH-1:0]  pcout_q,  pcout_nxt;
  logic [COUNT_WIDTH-1:0] count_q,  count_nxt;

  // State and registered outputs; reset overrides everything, including an open request
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_ADDR;
      req_q   <= 1'b0;
      addr_q  <= RESET_ADDR;
      valid_q <= 1'b0;
      instr_q <= '0;
      pcout_q <= '0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      valid_q <= valid_nxt;
      instr_q <= instr_nxt;
      pcout_q <= pcout_nxt;
      count_q <= count_nxt;
    end
  end

  // Next-state and next-output logic; redirect outranks every non-reset event
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    valid_nxt = valid_q;
    instr_nxt = instr_q;
    pcout_nxt = pcout_q;
    count_nxt = count_q;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
        req_nxt   = 1'b1;
        if (bus.redirect_valid) begin
          pc_nxt   = bus.redirect_target;
          addr_nxt = bus.redirect_target;
        end else begin
          addr_nxt = pc;
        end
      end

      ST_REQ: begin
        if (bus.redirect_valid) begin
          pc_nxt = bus.redirect_target;
          if (bus.imem_rvalid) begin
            // Returned word is stale: drop it and re-request at the target
            state_nxt = ST_REQ;
            req_nxt   = 1'b1;
            addr_nxt  = bus.redirect_target;
          end else begin
            // Request must stay up on its old address until it completes
            state_nxt = ST_DISCARD;
          end
        end else if (bus.imem_rvalid) begin
          state_nxt = ST_HOLD;
          req_nxt   = 1'b0;
          valid_nxt = 1'b1;
          instr_nxt = bus.imem_rdata;
          pcout_nxt = addr_q;
          pc_nxt    = pc + ADDR_WIDTH'(1);
        end
      end

      ST_HOLD: begin
        if (bus.instr_ready) begin
          count_nxt = count_q + COUNT_WIDTH'(1);
        end
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_target;
          valid_nxt = 1'b0;
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = bus.redirect_target;
        end else if (bus.instr_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = pc;
        end
      end

      ST_DISCARD: begin
        if (bus.redirect_valid) begin
          pc_nxt = bus.redirect_target;
        end
        if (bus.imem_rvalid) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = bus.redirect_valid ? bus.redirect_target : pc;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pcout_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory with
// programmable latency, scoreboard of expected (pc, word) pairs consumed at
// each decode handshake, plus a second instance reset at the top of the space.
module tb_fetch_unit;
  typedef struct packed {
    logic [15:0] pc;
    logic [18:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic const_mode;
  logic force_rvalid;
  logic [7:0] lat_cnt;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(19)) ifc ();
  fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(19)) ifc_w ();

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(19), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .bus(ifc.master)
  );

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(19), .RESET_PC(32'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .bus(ifc_w.master)
  );

  function automatic logic [18:0] data_of(input logic [15:0] a, input logic cm);
    return cm ? 19'h5A5A5 : {3'b101, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: count cycles the current request has been up
  always @(posedge clk) begin
    if (rst || !ifc.imem_req || ifc.imem_rvalid) lat_cnt <= 8'd0;
    else                                         lat_cnt <= lat_cnt + 8'd1;
  end

  assign ifc.imem_rvalid = force_rvalid | (ifc.imem_req && (32'(lat_cnt) == lat));
  assign ifc.imem_rdata  = force_rvalid ? 19'h7FFFF : data_of(ifc.imem_addr, const_mode);

  assign ifc_w.imem_rvalid     = ifc_w.imem_req;
  assign ifc_w.imem_rdata      = 19'h00001;
  assign ifc_w.instr_ready     = 1'b1;
  assign ifc_w.redirect_valid  = 1'b0;
  assign ifc_w.redirect_target = 16'h0000;

  // Scoreboard: every decode handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && ifc.instr_valid && ifc.instr_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'(ifc.pc_out), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pc", 32'(ifc.pc_out), 32'(mon_e.pc));
        check("sb_instr", 32'(ifc.instr_out), 32'(mon_e.instr));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ifc.instr_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    force_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin step(); n++; end while (!ifc.imem_req && n < 20);
    check(tag, 32'(ifc.imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin step(); n++; end while (!ifc.instr_valid && n < 20);
    check(tag, 32'(ifc.instr_valid), 32'd1);
  endtask

  task automatic wait_count(input logic [15:0] want, input string tag);
    int n = 0;
    while (ifc.fetch_count != want && n < 30) begin step(); n++; end
    check(tag, 32'(ifc.fetch_count), 32'(want));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(ifc.imem_req),    32'd0);
    check({tag, "_addr"},  32'(ifc.imem_addr),   32'd0);
    check({tag, "_valid"}, 32'(ifc.instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(ifc.instr_out),   32'd0);
    check({tag, "_pcout"}, 32'(ifc.pc_out),      32'd0);
    check({tag, "_count"}, 32'(ifc.fetch_count), 32'd0);
  endtask

  // PC wrap on the instance reset to the last address
  initial begin
    int n;
    n = 0;
    while (!ifc_w.imem_req && n < 50) begin @(posedge clk); #1; n++; end
    check("wrap_first_addr", 32'(ifc_w.imem_addr), 32'hFFFF);
    n = 0;
    while (ifc_w.imem_req && n < 10) begin @(posedge clk); #1; n++; end
    n = 0;
    while (!ifc_w.imem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("wrap_second_addr", 32'(ifc_w.imem_addr), 32'h0000);
  end

  initial begin
    logic [15:0] req_addr [3];
    int hs_at [3];
    int n_req;
    int hs_n;

    rst = 1'b1;
    ifc.instr_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_target = 16'h0000;
    lat = 0;
    const_mode = 1'b0;
    force_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin req_addr[i] = 16'hDEAD; hs_at[i] = 0; end

    step();
    step();
    check_reset_outputs("rst");

    // Zero-latency memory, decode always ready
    const_mode = 1'b1;
    lat = 0;
    ifc.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back('{pc: 16'(i), instr: 19'h5A5A5});
    rst = 1'b0;
    n_req = 0;
    hs_n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ifc.imem_req && n_req < 3) begin req_addr[n_req] = ifc.imem_addr; n_req++; end
      if (ifc.instr_valid && ifc.instr_ready && hs_n < 3) begin hs_at[hs_n] = i; hs_n++; end
      if (ifc.fetch_count == 16'd3) break;
    end
    check("t1_count", 32'(ifc.fetch_count), 32'd3);
    check("t1_addr0", 32'(req_addr[0]), 32'd0);
    check("t1_addr1", 32'(req_addr[1]), 32'd1);
    check("t1_addr2", 32'(req_addr[2]), 32'd2);
    check("t1_gap01", 32'(hs_at[1] - hs_at[0]), 32'd2);
    check("t1_gap12", 32'(hs_at[2] - hs_at[1]), 32'd2);
    check("t1_sb_left", 32'(sb_q.size()), 32'd0);

    // Latency 3, decode stalls for several cycles
    do_reset();
    const_mode = 1'b0;
    lat = 3;
    wait_req("t2_req");
    for (int i = 0; i < 10; i++) begin
      check("t2_addr_stable", 32'(ifc.imem_addr), 32'd0);
      if (ifc.imem_rvalid) break;
      step();
    end
    step();
    check("t2_valid", 32'(ifc.instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t2_stall_valid", 32'(ifc.instr_valid), 32'd1);
      check("t2_stall_instr", 32'(ifc.instr_out), 32'(data_of(16'h0000, 1'b0)));
      check("t2_stall_pc", 32'(ifc.pc_out), 32'd0);
      check("t2_stall_count", 32'(ifc.fetch_count), 32'd0);
      step();
    end
    sb_q.push_back('{pc: 16'h0000, instr: data_of(16'h0000, 1'b0)});
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    check("t2_count", 32'(ifc.fetch_count), 32'd1);
    check("t2_valid_drop", 32'(ifc.instr_valid), 32'd0);
    check("t2_sb_left", 32'(sb_q.size()), 32'd0);

    // Redirect while a request is outstanding: stale word must never surface
    do_reset();
    lat = 2;
    ifc.instr_ready = 1'b1;
    wait_req("t3_req");
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 16'h0040;
    sb_q.push_back('{pc: 16'h0040, instr: data_of(16'h0040, 1'b0)});
    step();
    ifc.redirect_valid = 1'b0;
    check("t3_disc_req", 32'(ifc.imem_req), 32'd1);
    check("t3_disc_addr", 32'(ifc.imem_addr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (ifc.imem_rvalid) break;
      step();
      check("t3_disc_valid", 32'(ifc.instr_valid), 32'd0);
    end
    step();
    check("t3_new_req", 32'(ifc.imem_req), 32'd1);
    check("t3_new_addr", 32'(ifc.imem_addr), 32'h0040);
    check("t3_valid_low", 32'(ifc.instr_valid), 32'd0);
    wait_count(16'd1, "t3_count");
    check("t3_sb_left", 32'(sb_q.size()), 32'd0);

    // Redirect in HOLD, without and then with a same-cycle handshake
    do_reset();
    lat = 0;
    wait_valid("t4_valid");
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 16'h0100;
    step();
    ifc.redirect_valid = 1'b0;
    check("t4a_valid", 32'(ifc.instr_valid), 32'd0);
    check("t4a_count", 32'(ifc.fetch_count), 32'd0);
    check("t4a_req", 32'(ifc.imem_req), 32'd1);
    check("t4a_addr", 32'(ifc.imem_addr), 32'h0100);
    sb_q.push_back('{pc: 16'h0100, instr: data_of(16'h0100, 1'b0)});
    wait_valid("t4b_valid");
    ifc.instr_ready = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 16'h0100;
    step();
    ifc.redirect_valid = 1'b0;
    ifc.instr_ready = 1'b0;
    check("t4b_count", 32'(ifc.fetch_count), 32'd1);
    check("t4b_valid", 32'(ifc.instr_valid), 32'd0);
    check("t4b_addr", 32'(ifc.imem_addr), 32'h0100);
    check("t4b_sb_left", 32'(sb_q.size()), 32'd0);

    // Redirect in the same cycle as the returned word
    do_reset();
    lat = 0;
    ifc.instr_ready = 1'b1;
    wait_req("t5_req");
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 16'h0020;
    sb_q.push_back('{pc: 16'h0020, instr: data_of(16'h0020, 1'b0)});
    step();
    ifc.redirect_valid = 1'b0;
    check("t5_valid", 32'(ifc.instr_valid), 32'd0);
    check("t5_addr", 32'(ifc.imem_addr), 32'h0020);
    wait_count(16'd1, "t5_count");
    check("t5_sb_left", 32'(sb_q.size()), 32'd0);

    // Reset mid-request, then a late rvalid while idle
    lat = 3;
    step();
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    force_rvalid = 1'b1;
    step();
    force_rvalid = 1'b0;
    check("t6_req", 32'(ifc.imem_req), 32'd1);
    check("t6_addr", 32'(ifc.imem_addr), 32'd0);
    check("t6_valid", 32'(ifc.instr_valid), 32'd0);
    sb_q.push_back('{pc: 16'h0000, instr: data_of(16'h0000, 1'b0)});
    wait_count(16'd1, "t6_count");
    check("t6_sb_left", 32'(sb_q.size()), 32'd0);

    ifc.instr_ready = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
